// File: rtl/rng_bit_packer_pkg.sv
// =============================================================================
// Module  : rng_pkg
// Brief   : Shared types and constants for the TRNG bit packer and its
//           transmit-side consumers.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

package rng_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ALARM = 1'b1
  } pack_state_t;

  localparam int RNG_WORD_WIDTH = 8;
  localparam int RNG_REP_LIMIT  = 32;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

endpackage

`default_nettype wire

// File: rtl/rng_bit_packer_if.sv
// =============================================================================
// Module  : rng_bit_packer_if
// Brief   : Valid/ready word stream from the packer holder to its consumer.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

interface rng_bit_packer_if
  import rng_pkg::*;
#(
  parameter int WORD_WIDTH = RNG_WORD_WIDTH
) ();

  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_out, output word_valid, input  word_ready);
  modport slave  (input  word_out, input  word_valid, output word_ready);

endinterface

`default_nettype wire

// File: rtl/rng_bit_packer_rep_counter.sv
// =============================================================================
// Module  : rng_rep_counter
// Brief   : Repetition-count health test; pulses trip_o on the raw bit that
//           brings the run of identical bits up to REP_LIMIT.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module rng_rep_counter
  import rng_pkg::*;
#(
  parameter int REP_LIMIT = RNG_REP_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en_i,
  input  logic bit_i,
  output logic trip_o
);

  localparam int CNT_W = $clog2(REP_LIMIT + 1);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             last_bit_q;

  // A fresh counter (0) with a matching last_bit still lands on 1.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (bit_i == last_bit_q) begin
      if (run_cnt_q != CNT_W'(REP_LIMIT)) run_cnt_d = run_cnt_q + 1'b1;
    end else begin
      run_cnt_d = CNT_W'(1);
    end
  end

  assign trip_o = en_i && (run_cnt_d == CNT_W'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run_cnt_q  <= '0;
      last_bit_q <= 1'b0;
    end else if (en_i) begin
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= bit_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rng_bit_packer.sv
// =============================================================================
// Module  : rng_bit_packer
// Brief   : Health-tested raw-bit packer with a one-word output holder and a
//           saturating drop counter. Define RNG_PACKER_DEBIAS_EN to insert a
//           von Neumann debiaser between the health test and the packer.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module rng_bit_packer
  import rng_pkg::*;
#(
  parameter int WORD_WIDTH = RNG_WORD_WIDTH,
  parameter int REP_LIMIT  = RNG_REP_LIMIT,
  parameter int DROP_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  rng_bit_packer_if.master             word_if,
  output logic [DROP_CNT_W-1:0]        drop_count,
  output logic                         rep_alarm,
  output logic [$clog2(WORD_WIDTH):0]  fill_level
);

  localparam int FILL_W = $clog2(WORD_WIDTH) + 1;

  pack_state_t           state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic                  valid_q, valid_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  alarm_q, alarm_d;
  logic                  accept, trip, pack_en, pack_bit, word_done;

`ifdef RNG_PACKER_DEBIAS_EN
  logic phase_q, phase_d;
  logic half_q, half_d;
`endif

  assign accept = bit_valid && !clear && (state_q == FILL);

  rng_rep_counter #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .en_i   (accept),
    .bit_i  (bit_in),
    .trip_o (trip)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    drop_d    = drop_q;
    alarm_d   = alarm_q;
    pack_en   = 1'b0;
    pack_bit  = bit_in;
    word_done = 1'b0;
`ifdef RNG_PACKER_DEBIAS_EN
    phase_d   = phase_q;
    half_d    = half_q;
`endif

    if (clear) begin
      state_d = FILL;
      shift_d = '0;
      fill_d  = '0;
      alarm_d = 1'b0;
`ifdef RNG_PACKER_DEBIAS_EN
      phase_d = 1'b0;
`endif
    end else if (accept) begin
      if (trip) begin
        state_d = ALARM;
        alarm_d = 1'b1;
        fill_d  = '0;
`ifdef RNG_PACKER_DEBIAS_EN
        phase_d = 1'b0;
`endif
      end else begin
`ifdef RNG_PACKER_DEBIAS_EN
        if (!phase_q) begin
          half_d  = bit_in;
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          pack_en  = (half_q != bit_in);
          pack_bit = half_q;
        end
`else
        pack_en = 1'b1;
`endif
      end
    end

    // Loading from the MSB end leaves the earliest bit at bit 0.
    if (pack_en) begin
      shift_d = {pack_bit, shift_q[WORD_WIDTH-1:1]};
      if (fill_q == FILL_W'(WORD_WIDTH - 1)) begin
        word_done = 1'b1;
        fill_d    = '0;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (word_done) begin
      if (!valid_q || word_if.word_ready) begin
        hold_d  = shift_d;
        valid_d = 1'b1;
      end else if (drop_q != {DROP_CNT_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (valid_q && word_if.word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      shift_q <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      alarm_q <= 1'b0;
`ifdef RNG_PACKER_DEBIAS_EN
      phase_q <= 1'b0;
      half_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      alarm_q <= alarm_d;
`ifdef RNG_PACKER_DEBIAS_EN
      phase_q <= phase_d;
      half_q  <= half_d;
`endif
    end
  end

  assign word_if.word_out   = hold_q;
  assign word_if.word_valid = valid_q;
  assign drop_count         = drop_q;
  assign rep_alarm          = alarm_q;
  assign fill_level         = fill_q;

endmodule

`default_nettype wire

// File: doc/rng_bit_packer.md
Name: rng_bit_packer

Overview:
- Sits between the oscillator-XOR sampler and the capture memory / UART path of the TRNG.
- Accepts one raw random bit per sample strobe and runs a repetition-count health test on it.
- Packs the bits into WORD_WIDTH-bit words and presents each word on a valid/ready output with a one-word holding register.
- Words that complete while the holder is occupied are dropped and counted; they never stall the sampler.

Parameters:
- WORD_WIDTH, 8, bits per packed output word (>=2).
- REP_LIMIT, 32, consecutive identical raw bits that trip the health alarm (>=2).
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock (CLOCK_50 at top).
- reset  input  1  synchronous, active-high reset.
- clear  input  1  sync soft clear: partial word, run counter, alarm, debias phase; holder and drop_count untouched.
- bit_in  input  1  raw sampled bit; qualified by bit_valid.
- bit_valid  input  1  one-cycle strobe, one per sample period.
- word_out  output  WORD_WIDTH  packed word; LSB = earliest bit.
- word_valid  output  1  holder occupied.
- word_ready  input  1  consumer accepts when word_valid & word_ready.
- drop_count  output  DROP_CNT_W  words lost to a full holder; saturates at all-ones.
- rep_alarm  output  1  sticky health-test failure.
- fill_level  output  $clog2(WORD_WIDTH)+1  bits currently in the partial word.

Behaviour:
- Reset values: word_out=0, word_valid=0, drop_count=0, rep_alarm=0, fill_level=0. Run counter=0, last_bit=0, debias phase=0.
- Reset has priority over clear. Clear has priority over bit_valid in the same cycle.
- Health test runs on every raw bit with bit_valid=1, before debias.
  - bit == last_bit: run_cnt increments, saturating at REP_LIMIT.
  - Otherwise: run_cnt=1, last_bit=bit.
  - The first bit after reset/clear sets run_cnt=1.
- Pack FSM:
  - FILL: accepted bits are shifted in. The shift register loads from the MSB end, so the first accepted bit ends up at bit 0 of the completed word. fill_level increments.
  - On the bit where run_cnt reaches REP_LIMIT: that bit is not packed, rep_alarm=1, and the FSM enters ALARM.
  - ALARM: all bits are discarded, fill_level=0, health state frozen. Exit only via clear or reset, both returning to FILL. Holder drain continues.
- Word completion happens on the edge that accepts bit WORD_WIDTH; fill_level returns to 0.
  - If the holder is empty, or is being consumed this cycle, the word loads into the holder. word_valid is 1 from the next cycle, so latency is 1 cycle from the last bit's strobe.
  - Otherwise the word is discarded and drop_count increments (saturating).
- Holder rules:
  - word_out is stable while word_valid=1.
  - word_valid deasserts the cycle after a handshake, unless a completed word reloads the holder on that same edge, in which case word_valid stays 1 with the new data.
  - word_ready while word_valid=0 has no effect.

Optional Feature:
- Macro: RNG_PACKER_DEBIAS_EN.
- Defined: von Neumann debias between the health test and the packer.
  - Raw bits are taken in pairs (phase toggles per accepted raw bit).
  - Pair 01 packs 0, pair 10 packs 1; pairs 00 and 11 pack nothing.
  - Phase resets on reset, clear and ALARM entry.
  - The alarm-tripping bit also discards any pending half-pair.
- Undefined: every accepted raw bit is packed directly; no phase register exists.

Decomposition:
- Package rng_pkg:
  - pack_state_t enum {FILL, ALARM}.
  - Default constants RNG_WORD_WIDTH=8, RNG_REP_LIMIT=32.
  - ASCII constants ASCII_ZERO=8'h30, ASCII_ONE=8'h31, shared with the transmit path.
- Sub-module rng_rep_counter holds the run-length counter and last_bit, and outputs a trip pulse. Packing, the holder and the drop counter stay in the parent.

Test Plan:
- Reset, then strobe bits 1,0,1,1,0,0,1,0 with word_ready=1 and macro off -> word_out=8'h4D, word_valid for 1 cycle, starting 1 cycle after the 8th strobe.
- word_ready=0, push 24 alternating bits (1,0,...) -> first word 8'h55 held, drop_count=2; then word_ready=1 -> single handshake, word_valid=0.
- 32 consecutive 1s -> rep_alarm=1 on the 32nd strobe; fill_level=7 after the 31st strobe, then fill_level=0; no word emitted. Further bits ignored until clear, after which 8 more bits produce a word.
- Word completion on the same edge as a handshake -> word_valid stays 1 and word_out updates; drop_count unchanged.
- Macro on, raw pairs 01,10,11,00,10,10,01,01,10,01 -> 8 debiased bits 0,1,1,1,0,0,1,0 -> word_out=8'h4E.
- Mid-word clear after 5 bits -> fill_level=0; a held word remains valid, and the next 8 bits form a fresh word.
